// File: rtl/tc_div_pkg.sv
// ---------------------------------------------------------------------------
// tc_div_pkg : shared widths, types and limits for the TC sequential divider, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tc_div_pkg;

  localparam int DIVIDEND_W = 31;
  localparam int DIVISOR_W  = 13;
  localparam int QUOT_W     = 18;
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

  localparam int QUOT_POS_LIM = (1 << (QUOT_W - 1)) - 1;
  localparam int QUOT_NEG_LIM = (1 << (QUOT_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [DIVIDEND_W-1:0]    dmag_t;
  typedef logic [DIVISOR_W:0]       prem_t;
  typedef logic signed [QUOT_W-1:0] quot_t;

  localparam quot_t QUOT_MAX = quot_t'(QUOT_POS_LIM);
  localparam quot_t QUOT_MIN = quot_t'(-QUOT_NEG_LIM);

endpackage

`default_nettype wire

// File: rtl/trackletcalculator_div_31s_13ns_18s_seq_if.sv
// ---------------------------------------------------------------------------
// trackletcalculator_div_31s_13ns_18s_seq_if : ap-handshake + operand/result bundle, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface trackletcalculator_div_31s_13ns_18s_seq_if;
  import tc_div_pkg::*;

  logic                         ap_start;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic        [DIVISOR_W-1:0]  divisor;
  logic                         ap_idle;
  logic                         ap_ready;
  logic                         ap_done;
  quot_t                        quotient;
  logic signed [DIVISOR_W:0]    remainder;
  logic                         ovf;
  logic                         div_by_zero;

  modport slave (
    input  ap_start, dividend, divisor,
    output ap_idle, ap_ready, ap_done, quotient, remainder, ovf, div_by_zero
  );

  modport master (
    output ap_start, dividend, divisor,
    input  ap_idle, ap_ready, ap_done, quotient, remainder, ovf, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/tc_div_restoring_step.sv
// ---------------------------------------------------------------------------
// tc_div_restoring_step : one combinational restoring-division iteration, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tc_div_restoring_step
  import tc_div_pkg::*;
(
  input  prem_t                rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output prem_t                rem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W+1:0] w_partial;
  logic [DIVISOR_W+1:0] w_divisor;
  logic [DIVISOR_W+1:0] w_diff;

  assign w_partial = {rem_i, bit_i};
  assign w_divisor = {2'b00, divisor_i};
  assign w_diff    = w_partial - w_divisor;
  assign qbit_o    = (w_partial >= w_divisor);
  // Result is always < divisor when the subtract is taken, so it fits the narrower register.
  assign rem_o     = prem_t'(qbit_o ? w_diff : w_partial);

endmodule

`default_nettype wire

// File: rtl/trackletcalculator_div_31s_13ns_18s_seq.sv
// ---------------------------------------------------------------------------
// trackletcalculator_div_31s_13ns_18s_seq : 31s / 13u restoring divider, 18s saturated quotient, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trackletcalculator_div_31s_13ns_18s_seq
  import tc_div_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst_n,
  trackletcalculator_div_31s_13ns_18s_seq_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  dmag_t                dmag_q, dmag_d;
  dmag_t                qmag_q, qmag_d;
  prem_t                rem_q, rem_d;
  logic                 neg_q, neg_d;
  logic [DIVISOR_W-1:0] dvs_q, dvs_d;
  quot_t                quot_q, quot_d;
  prem_t                remo_q, remo_d;
  logic                 ovf_q, ovf_d;
  logic                 dbz_q, dbz_d;

  prem_t                w_step_rem;
  logic                 w_step_qbit;
  dmag_t                w_qmag_next;
  dmag_t                w_dabs;
  logic [QUOT_W-1:0]    w_qlo;
  logic [QUOT_W-1:0]    w_qlo_neg;
  prem_t                w_rem_neg;

  tc_div_restoring_step u_step (
    .rem_i     (rem_q),
    .bit_i     (dmag_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (w_step_rem),
    .qbit_o    (w_step_qbit)
  );

  // |-2^30| = 2^30 still fits the unsigned magnitude width.
  assign w_dabs      = bus.dividend[DIVIDEND_W-1] ? (~dmag_t'(bus.dividend) + dmag_t'(1))
                                                  : dmag_t'(bus.dividend);
  assign w_qmag_next = (qmag_q << 1) | dmag_t'(w_step_qbit);
  assign w_qlo       = w_qmag_next[QUOT_W-1:0];
  assign w_qlo_neg   = QUOT_W'(0) - w_qlo;
  assign w_rem_neg   = prem_t'(0) - w_step_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dmag_d  = dmag_q;
    qmag_d  = qmag_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          state_d = CALC;
          neg_d   = bus.dividend[DIVIDEND_W-1];
          dmag_d  = w_dabs;
          dvs_d   = bus.divisor;
          cnt_d   = CNT_W'(DIVIDEND_W);
          rem_d   = '0;
          qmag_d  = '0;
        end
      end
      CALC: begin
        dmag_d = dmag_q << 1;
        rem_d  = w_step_rem;
        qmag_d = w_qmag_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (dvs_q == '0) begin
            quot_d = neg_q ? QUOT_MIN : QUOT_MAX;
            remo_d = '0;
            ovf_d  = 1'b0;
            dbz_d  = 1'b1;
          end else begin
            remo_d = neg_q ? w_rem_neg : w_step_rem;
            dbz_d  = 1'b0;
            if (!neg_q && (w_qmag_next > dmag_t'(QUOT_POS_LIM))) begin
              quot_d = QUOT_MAX;
              ovf_d  = 1'b1;
            end else if (neg_q && (w_qmag_next > dmag_t'(QUOT_NEG_LIM))) begin
              quot_d = QUOT_MIN;
              ovf_d  = 1'b1;
            end else begin
              quot_d = neg_q ? quot_t'(w_qlo_neg) : quot_t'(w_qlo);
              ovf_d  = 1'b0;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dmag_q  <= '0;
      qmag_q  <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dmag_q  <= dmag_d;
      qmag_q  <= qmag_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ap_idle     = (state_q == IDLE);
  assign bus.ap_ready    = (state_q == IDLE) && bus.ap_start;
  assign bus.ap_done     = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.ovf         = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_trackletcalculator_div_31s_13ns_18s_seq.sv
// ---------------------------------------------------------------------------
// tb_trackletcalculator_div_31s_13ns_18s_seq : scoreboard bench for the TC divider, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trackletcalculator_div_31s_13ns_18s_seq;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  trackletcalculator_div_31s_13ns_18s_seq_if bus ();

  trackletcalculator_div_31s_13ns_18s_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic signed [17:0] q;
    logic signed [13:0] r;
    logic               ovf;
    logic               dbz;
  } res_t;

  res_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic res_t model(input logic signed [30:0] a, input logic [12:0] b);
    res_t   e;
    longint sa, sb, q, r;
    sa = longint'(a);
    sb = longint'(b);
    e  = '0;
    if (sb == 0) begin
      e.q   = (sa < 0) ? 18'h20000 : 18'h1FFFF;
      e.dbz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      if (q > 131071) begin
        q = 131071;
        e.ovf = 1'b1;
      end else if (q < -131072) begin
        q = -131072;
        e.ovf = 1'b1;
      end
      e.q = 18'(q);
      e.r = 14'(r);
    end
    return e;
  endfunction

  function automatic res_t obs();
    return {bus.quotient, bus.remainder, bus.ovf, bus.div_by_zero};
  endfunction

  function automatic logic signed [30:0] rand_dividend();
    case ($urandom_range(0, 3))
      0:       return 31'($urandom);
      1:       return 31'(int'($urandom_range(0, 2000)) - 1000);
      2:       return 31'(int'($urandom_range(0, 600000)) - 300000);
      default: return 31'h40000000;
    endcase
  endfunction

  function automatic logic [12:0] rand_divisor();
    case ($urandom_range(0, 7))
      0:       return 13'd0;
      1, 2:    return 13'($urandom_range(1, 15));
      default: return 13'($urandom);
    endcase
  endfunction

  task automatic issue(input logic signed [30:0] a, input logic [12:0] b, input res_t e);
    @(negedge ap_clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.ap_start = 1'b1;
    sb_q.push_back(e);
    @(posedge ap_clk);
    #1;
    bus.ap_start = 1'b0;
    bus.dividend = rand_dividend();
    bus.divisor  = rand_divisor();
  endtask

  // cyc is the cycle index of ap_done, counting the acceptance cycle as 0.
  task automatic wait_done(output int cyc, output bit ok, output bit moved);
    res_t o0;
    o0    = obs();
    cyc   = 1;
    ok    = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      if (bus.ap_done) begin
        ok = 1'b1;
        break;
      end
      if (obs() !== o0) moved = 1'b1;
      @(posedge ap_clk);
      cyc++;
    end
  endtask

  task automatic run_one(input logic signed [30:0] a, input logic [12:0] b, input res_t e,
                         output res_t got, output res_t want, output int cyc,
                         output bit ok, output bit moved);
    issue(a, b, e);
    wait_done(cyc, ok, moved);
    got  = obs();
    want = sb_q.pop_front();
  endtask

  task automatic test_reset();
    bus.ap_start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    ap_rst_n     = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    n_tests++;
    if ({bus.ap_idle, bus.ap_done, bus.ap_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_handshake: idle/done/ready=%b want 100",
               {bus.ap_idle, bus.ap_done, bus.ap_ready});
    end
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", obs());
    end
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic signed [30:0] a [3] = '{-31'sd300000, -31'sd7, 31'sd7};
    logic        [12:0] b [3] = '{13'd1000, 13'd2, 13'd2};
    res_t               e [3] = '{'{-18'sd300, 14'sd0, 1'b0, 1'b0},
                                  '{-18'sd3, -14'sd1, 1'b0, 1'b0},
                                  '{18'sd3, 14'sd1, 1'b0, 1'b0}};
    res_t got, want;
    int   cyc;
    bit   ok, moved;
    for (int i = 0; i < 3; i++) begin
      run_one(a[i], b[i], e[i], got, want, cyc, ok, moved);
      n_tests++;
      if (!ok || cyc !== 32) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: done=%0b at cycle %0d want cycle 32", i, ok, cyc);
      end
      n_tests++;
      if (moved) begin
        n_fail++;
        $display("FAIL basic_hold[%0d]: outputs changed during CALC, want stable", i);
      end
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic_result[%0d]: got q=%0d r=%0d ovf=%0b dbz=%0b want q=%0d r=%0d ovf=%0b dbz=%0b",
                 i, got.q, got.r, got.ovf, got.dbz, want.q, want.r, want.ovf, want.dbz);
      end
    end
  endtask

  task automatic test_div_zero();
    logic signed [30:0] a [2] = '{31'sd5, -31'sd5};
    res_t               e [2] = '{'{18'h1FFFF, 14'sd0, 1'b0, 1'b1},
                                  '{18'h20000, 14'sd0, 1'b0, 1'b1}};
    res_t got, want;
    int   cyc;
    bit   ok, moved;
    for (int i = 0; i < 2; i++) begin
      run_one(a[i], 13'd0, e[i], got, want, cyc, ok, moved);
      n_tests++;
      if (!ok || cyc !== 32) begin
        n_fail++;
        $display("FAIL dbz_latency[%0d]: done=%0b at cycle %0d want cycle 32", i, ok, cyc);
      end
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL dbz_result[%0d]: got q=%0d r=%0d ovf=%0b dbz=%0b want q=%0d r=%0d ovf=%0b dbz=%0b",
                 i, got.q, got.r, got.ovf, got.dbz, want.q, want.r, want.ovf, want.dbz);
      end
    end
  endtask

  task automatic test_overflow();
    logic signed [30:0] a [7] = '{31'sh3FFFFFFF, -31'sd131072, -31'sd131073, 31'sd131072,
                                  31'sd0, 31'sh40000000, 31'sd100000};
    logic        [12:0] b [7] = '{13'd1, 13'd1, 13'd1, 13'd1, 13'd5, 13'd8191, 13'd8191};
    res_t               e [7] = '{'{18'h1FFFF, 14'sd0, 1'b1, 1'b0},
                                  '{18'h20000, 14'sd0, 1'b0, 1'b0},
                                  '{18'h20000, 14'sd0, 1'b1, 1'b0},
                                  '{18'h1FFFF, 14'sd0, 1'b1, 1'b0},
                                  '{18'sd0, 14'sd0, 1'b0, 1'b0},
                                  '{18'h20000, -14'sd16, 1'b1, 1'b0},
                                  '{18'sd12, 14'sd1708, 1'b0, 1'b0}};
    res_t got, want;
    int   cyc;
    bit   ok, moved;
    for (int i = 0; i < 7; i++) begin
      run_one(a[i], b[i], e[i], got, want, cyc, ok, moved);
      n_tests++;
      if (!ok || got !== want) begin
        n_fail++;
        $display("FAIL ovf_result[%0d]: done=%0b got q=%0d r=%0d ovf=%0b dbz=%0b want q=%0d r=%0d ovf=%0b dbz=%0b",
                 i, ok, got.q, got.r, got.ovf, got.dbz, want.q, want.r, want.ovf, want.dbz);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t got, want;
    int   cyc, dones;
    bit   ok, moved;
    @(negedge ap_clk);
    bus.dividend = 31'sd1000000;
    bus.divisor  = 13'd3;
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.ap_start = 1'b0;
    repeat (9) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: idle=%b done=%b want idle=1 done=0", bus.ap_idle, bus.ap_done);
    end
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h want 0", obs());
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge ap_clk);
      if (bus.ap_done) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: saw %0d ap_done pulses want 0", dones);
    end
    run_one(31'sd100, 13'd7, '{18'sd14, 14'sd2, 1'b0, 1'b0}, got, want, cyc, ok, moved);
    n_tests++;
    if (!ok || got !== want) begin
      n_fail++;
      $display("FAIL midreset_next: done=%0b got q=%0d r=%0d want q=%0d r=%0d",
               ok, got.q, got.r, want.q, want.r);
    end
  endtask

  task automatic test_back_to_back(input int n_ops);
    int   cyc = 0, last = -1, issued = 0, checked = 0;
    res_t got, want;
    @(posedge ap_clk);
    #1;
    bus.ap_start = 1'b1;
    bus.dividend = rand_dividend();
    bus.divisor  = rand_divisor();
    while (checked < n_ops && cyc < n_ops * 33 + 200) begin
      @(negedge ap_clk);
      if (bus.ap_ready) begin
        if (last >= 0) begin
          n_tests++;
          if (cyc - last !== 33) begin
            n_fail++;
            $display("FAIL b2b_ready_gap: gap %0d cycles want 33", cyc - last);
          end
        end
        last = cyc;
        sb_q.push_back(model(bus.dividend, bus.divisor));
        issued++;
      end
      if (bus.ap_done) begin
        got = obs();
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_done: got q=%0d with empty scoreboard want no done", got.q);
        end else begin
          want = sb_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got q=%0d r=%0d ovf=%0b dbz=%0b want q=%0d r=%0d ovf=%0b dbz=%0b",
                     checked, got.q, got.r, got.ovf, got.dbz, want.q, want.r, want.ovf, want.dbz);
          end
        end
        checked++;
      end
      @(posedge ap_clk);
      #1;
      if (issued >= n_ops) bus.ap_start = 1'b0;
      bus.dividend = rand_dividend();
      bus.divisor  = rand_divisor();
      cyc++;
    end
    bus.ap_start = 1'b0;
    n_tests++;
    if (checked !== n_ops) begin
      n_fail++;
      $display("FAIL b2b_count: completed %0d ops want %0d", checked, n_ops);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_back_to_back(300);
    n_tests++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
